keypad_scan_ctrl: RTL and testbench

//  Clocked scan controller for the 4x3 safe keypad. Drives the row lines one-hot and samples the

---
 rtl/safe_pkg.sv | 31 +++
 rtl/keypad_key_decoder.sv | 48 ++++
 rtl/keypad_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Definitions shared by the safe's keypad scanner, password comparator and state manager:
// key code constants, the scan state encoding and a small column helper.
package safe_pkg;

    localparam logic [3:0] KEY_0     = 4'h0;
    localparam logic [3:0] KEY_1     = 4'h1;
    localparam logic [3:0] KEY_2     = 4'h2;
    localparam logic [3:0] KEY_3     = 4'h3;
    localparam logic [3:0] KEY_4     = 4'h4;
    localparam logic [3:0] KEY_5     = 4'h5;
    localparam logic [3:0] KEY_6     = 4'h6;
    localparam logic [3:0] KEY_7     = 4'h7;
    localparam logic [3:0] KEY_8     = 4'h8;
    localparam logic [3:0] KEY_9     = 4'h9;
    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_SHARP = 4'hB;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        HOLD,
        RELEASE
    } scan_state_e;

    // A column sample names a single key only when exactly one line is high.
    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/keypad_key_decoder.sv
// Combinational map from (scanned row, one-hot column) to the safe's 4-bit key code.
module keypad_key_decoder
    import safe_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [2:0] col,
    output logic [3:0] key_code
);

    always_comb begin
        key_code = KEY_0;
        case (row_idx)
            2'd0: begin
                case (col)
                    3'b001:  key_code = KEY_1;
                    3'b010:  key_code = KEY_2;
                    3'b100:  key_code = KEY_3;
                    default: key_code = KEY_0;
                endcase
            end
            2'd1: begin
                case (col)
                    3'b001:  key_code = KEY_4;
                    3'b010:  key_code = KEY_5;
                    3'b100:  key_code = KEY_6;
                    default: key_code = KEY_0;
                endcase
            end
            2'd2: begin
                case (col)
                    3'b001:  key_code = KEY_7;
                    3'b010:  key_code = KEY_8;
                    3'b100:  key_code = KEY_9;
                    default: key_code = KEY_0;
                endcase
            end
            default: begin
                case (col)
                    3'b001:  key_code = KEY_STAR;
                    3'b010:  key_code = KEY_0;
                    3'b100:  key_code = KEY_SHARP;
                    default: key_code = KEY_0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x3 safe keypad scanner: one-hot row strobe, synchronized column sampling, press/release
// debounce, and a single key_valid pulse with its key code per physical press.
module keypad_scan_ctrl
    import safe_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] col_sense,
    output logic [3:0] row_drive,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_star,
    output logic       key_sharp,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    scan_state_e      state, state_nxt;
    logic [1:0]       row_idx, row_nxt;
    logic [CNT_W-1:0] div_cnt, div_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_nxt;
    logic [2:0]       col_lat, col_lat_nxt;
    logic [2:0]       col_p0, col_s;
    logic             code_load;
    logic [3:0]       dec_code;

    // Stage p0 -> s: two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p0 <= 3'b000;
            col_s  <= 3'b000;
        end else begin
            col_p0 <= col_sense;
            col_s  <= col_p0;
        end
    end

    keypad_key_decoder u_dec (
        .row_idx  (row_idx),
        .col      (col_lat),
        .key_code (dec_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCAN;
            row_idx  <= 2'd0;
            div_cnt  <= '0;
            deb_cnt  <= '0;
            col_lat  <= 3'b000;
            key_code <= KEY_0;
        end else begin
            state   <= state_nxt;
            row_idx <= row_nxt;
            div_cnt <= div_nxt;
            deb_cnt <= deb_nxt;
            col_lat <= col_lat_nxt;
            if (code_load) begin
                key_code <= dec_code;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        row_nxt     = row_idx;
        div_nxt     = div_cnt;
        deb_nxt     = deb_cnt;
        col_lat_nxt = col_lat;
        code_load   = 1'b0;

        if (!enable) begin
            // Idle discards any press in progress; key_code is deliberately left alone.
            state_nxt = SCAN;
            row_nxt   = 2'd0;
            div_nxt   = '0;
            deb_nxt   = '0;
        end else begin
            case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_nxt = '0;
                        if (is_onehot3(col_s)) begin
                            col_lat_nxt = col_s;
                            deb_nxt     = '0;
                            state_nxt   = DEBOUNCE;
                        end else begin
                            row_nxt = row_idx + 2'd1;
                        end
                    end else begin
                        div_nxt = div_cnt + CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_s == col_lat) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_nxt   = '0;
                            code_load = 1'b1;
                            state_nxt = EMIT;
                        end else begin
                            deb_nxt = deb_cnt + CNT_W'(1);
                        end
                    end else begin
                        deb_nxt   = '0;
                        row_nxt   = row_idx + 2'd1;
                        state_nxt = SCAN;
                    end
                end
                EMIT: begin
                    state_nxt = HOLD;
                end
                HOLD: begin
                    // Any column activity keeps the scanner parked on the frozen row.
                    if (col_s == 3'b000) begin
                        deb_nxt   = '0;
                        state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    if (col_s != 3'b000) begin
                        deb_nxt   = '0;
                        state_nxt = HOLD;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_nxt   = '0;
                        div_nxt   = '0;
                        row_nxt   = row_idx + 2'd1;
                        state_nxt = SCAN;
                    end else begin
                        deb_nxt = deb_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = SCAN;
                    deb_nxt   = '0;
                    div_nxt   = '0;
                end
            endcase
        end
    end

    assign row_drive = enable ? (4'b0001 << row_idx) : 4'b0000;
    assign key_valid = (state == EMIT);
    assign key_star  = key_valid && (key_code == KEY_STAR);
    assign key_sharp = key_valid && (key_code == KEY_SHARP);
    assign key_held  = (state == EMIT) || (state == HOLD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEB_CYCLES=8 and a simple keypad model.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] col_sense;
    logic [3:0] row_drive;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_star;
    logic       key_sharp;
    logic       key_held;

    // Keypad model: pressed keys connect their row line to their column lines.
    logic [3:0] press_rows;
    logic [2:0] press_cols;
    logic       ovr_en;
    logic [2:0] ovr_col;

    always_comb begin
        if (ovr_en)
            col_sense = ovr_col;
        else if ((row_drive & press_rows) != 4'b0000)
            col_sense = press_cols;
        else
            col_sense = 3'b000;
    end

    keypad_scan_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .col_sense (col_sense),
        .row_drive (row_drive),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_star  (key_star),
        .key_sharp (key_sharp),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rows;
        logic [2:0] cols;
        logic [3:0] code;
        logic       star;
        logic       sharp;
        int         lat;
    } key_vec_t;

    key_vec_t kv_tab [12];

    int n_vec = 0;
    int n_bad = 0;
    int cyc;
    int pulses;
    int pulse_cyc;
    logic [3:0] pulse_code;
    logic pulse_star;
    logic pulse_sharp;
    int stray;
    int held_last;
    int held_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; pulses = 0; pulse_cyc = -1; pulse_code = 4'h0;
        pulse_star = 1'b0; pulse_sharp = 1'b0; stray = 0; held_last = -1; held_cnt = 0;
    endtask

    // Advance to the next falling edge and record what the outputs did this cycle.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (key_valid) begin
            pulses++;
            pulse_cyc   = cyc;
            pulse_code  = key_code;
            pulse_star  = key_star;
            pulse_sharp = key_sharp;
        end
        if ((key_star || key_sharp) && !key_valid) stray++;
        if (key_held) begin
            held_last = cyc;
            held_cnt++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b1; ovr_en = 1'b0; ovr_col = 3'b000;
        press_rows = 4'b0000; press_cols = 3'b000;
        step();
        rst_n = 1'b1;
        clear_mon();
    endtask

    initial begin
        kv_tab[0]  = '{4'b0001, 3'b001, 4'h1, 1'b0, 1'b0, 12};
        kv_tab[1]  = '{4'b0001, 3'b010, 4'h2, 1'b0, 1'b0, 12};
        kv_tab[2]  = '{4'b0001, 3'b100, 4'h3, 1'b0, 1'b0, 12};
        kv_tab[3]  = '{4'b0010, 3'b001, 4'h4, 1'b0, 1'b0, 16};
        kv_tab[4]  = '{4'b0010, 3'b010, 4'h5, 1'b0, 1'b0, 16};
        kv_tab[5]  = '{4'b0010, 3'b100, 4'h6, 1'b0, 1'b0, 16};
        kv_tab[6]  = '{4'b0100, 3'b001, 4'h7, 1'b0, 1'b0, 20};
        kv_tab[7]  = '{4'b0100, 3'b010, 4'h8, 1'b0, 1'b0, 20};
        kv_tab[8]  = '{4'b0100, 3'b100, 4'h9, 1'b0, 1'b0, 20};
        kv_tab[9]  = '{4'b1000, 3'b001, 4'hA, 1'b1, 1'b0, 24};
        kv_tab[10] = '{4'b1000, 3'b010, 4'h0, 1'b0, 1'b0, 24};
        kv_tab[11] = '{4'b1000, 3'b100, 4'hB, 1'b0, 1'b1, 24};

        // Reset values, with rows gated by enable.
        rst_n = 1'b0; enable = 1'b0; ovr_en = 1'b0; ovr_col = 3'b000;
        press_rows = 4'b0000; press_cols = 3'b000;
        clear_mon();
        @(negedge clk);
        check("rst_row_en0", 32'(row_drive), 32'h0);
        check("rst_outputs", 32'({key_valid, key_star, key_sharp, key_held}), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        enable = 1'b1;
        #1;
        check("rst_row_en1", 32'(row_drive), 32'h1);

        // Free-running scan with no keys: 4 clocks per row.
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        for (int k = 1; k <= 20; k++) begin
            step();
            check("scan_row", 32'(row_drive), 32'(4'b0001 << ((k / 4) % 4)));
        end
        check("scan_no_pulse", pulses, 0);

        // Every key: latency, code, star/sharp, held window and row advance after release.
        for (int i = 0; i < 12; i++) begin
            int rel;
            do_reset();
            press_rows = kv_tab[i].rows;
            press_cols = kv_tab[i].cols;
            rel = kv_tab[i].lat + 14;
            while (cyc < rel) step();
            press_rows = 4'b0000;
            press_cols = 3'b000;
            repeat (11) step();
            check("key_next_row", 32'(row_drive), 32'({kv_tab[i].rows[2:0], kv_tab[i].rows[3]}));
            repeat (9) step();
            check("key_pulses", pulses, 1);
            check("key_latency", pulse_cyc, kv_tab[i].lat);
            check("key_code", 32'(pulse_code), 32'(kv_tab[i].code));
            check("key_star", 32'(pulse_star), 32'(kv_tab[i].star));
            check("key_sharp", 32'(pulse_sharp), 32'(kv_tab[i].sharp));
            check("key_stray_ss", stray, 0);
            check("key_held_end", held_last, rel + 10);
            check("key_held_len", held_cnt, rel + 10 - kv_tab[i].lat + 1);
            check("key_code_hold", 32'(key_code), 32'(kv_tab[i].code));
        end

        // Bouncing press and bouncing release: a single pulse.
        do_reset();
        ovr_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ovr_col = ((i % 6) < 3) ? 3'b010 : 3'b000;
            step();
        end
        check("bounce_quiet", pulses, 0);
        ovr_col = 3'b010;
        repeat (20) step();
        check("bounce_press", pulses, 1);
        for (int i = 0; i < 40; i++) begin
            ovr_col = ((i % 6) < 3) ? 3'b000 : 3'b010;
            step();
        end
        check("bounce_held", 32'(key_held), 32'h1);
        ovr_col = 3'b000;
        repeat (30) step();
        check("bounce_total", pulses, 1);
        check("bounce_released", 32'(key_held), 32'h0);
        ovr_en = 1'b0;

        // Two keys on row 1 form a multi-column sample: ignored, scan keeps rotating.
        do_reset();
        press_rows = 4'b0001;
        press_cols = 3'b011;
        repeat (40) step();
        check("ghost_pulses", pulses, 0);
        check("ghost_row", 32'(row_drive), 32'h4);
        press_rows = 4'b0100;
        press_cols = 3'b010;
        repeat (60) step();
        check("hold8_pulses", pulses, 1);
        check("hold8_code", 32'(pulse_code), 32'h8);
        check("hold8_held", held_last, 100);

        // Enable drop mid-debounce, restart at row 1, then async reset while holding.
        do_reset();
        press_rows = 4'b0010;
        press_cols = 3'b010;
        repeat (20) step();
        press_rows = 4'b0000;
        repeat (20) step();
        enable = 1'b0;
        step();
        check("en_off_row", 32'(row_drive), 32'h0);
        repeat (4) step();
        check("en_off_code", 32'(key_code), 32'h5);
        enable = 1'b1;
        press_rows = 4'b0100;
        press_cols = 3'b100;
        clear_mon();
        repeat (14) step();
        enable = 1'b0;
        step();
        check("deb_drop_row", 32'(row_drive), 32'h0);
        check("deb_drop_held", 32'({key_valid, key_held}), 32'h0);
        repeat (10) step();
        check("deb_drop_pulses", pulses, 0);
        check("deb_drop_code", 32'(key_code), 32'h5);
        enable = 1'b1;
        clear_mon();
        step();
        check("restart_row", 32'(row_drive), 32'h1);
        while (cyc < 22) step();
        check("restart_pulse", pulse_cyc, 20);
        check("restart_code", 32'(pulse_code), 32'h9);
        check("restart_held", 32'(key_held), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_held", 32'(key_held), 32'h0);
        check("async_rst_row", 32'(row_drive), 32'h1);
        check("async_rst_code", 32'(key_code), 32'h0);
        press_rows = 4'b0000;
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
